baggage_drop_seq: RTL and testbench

- Sequential controller for the baggage-drop datapath.
- On a start pulse it captures the four height sensors and the time limit, then derives the height and runs a bit-serial square root through a handshake with its sub-module. It halves the root into the drop time and compares that against the limit.
- On a pass it drives the drop actuator for a fixed hold period, followed by a cooldown.
- It sits between the sensor front-end and the display/drop stage and replaces the single-cycle combinational path with a multi-cycle, clocked sequence.

---
 rtl/baggage_pkg.sv | 26 ++
 rtl/baggage_drop_seq_if.sv | 31 +++
 rtl/isqrt_seq.sv | 78 +++++++
 rtl/baggage_drop_seq.sv | 190 +++++++++++++++++++
 tb/tb_baggage_drop_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/baggage_pkg.sv
// Shared types and constants for the baggage-drop sequencer and its square-root engine.
package baggage_pkg;

    localparam int RAD_W  = 24;
    localparam int ROOT_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_SQRT = 3'd2,
        ST_CMP  = 3'd3,
        ST_DROP = 3'd4,
        ST_COOL = 3'd5
    } state_t;

    localparam logic [1:0] VERDICT_NONE = 2'b00;
    localparam logic [1:0] VERDICT_DROP = 2'b01;
    localparam logic [1:0] VERDICT_SLOW = 2'b10;
    localparam logic [1:0] VERDICT_DIS  = 2'b11;

    // Q4.8 root halved into a Q8.8 drop time, truncating the dropped LSB.
    function automatic logic [15:0] root_to_drop_time(input logic [ROOT_W-1:0] root);
        return 16'({4'b0000, root} >> 1);
    endfunction

endpackage

// File: rtl/baggage_drop_seq_if.sv
// Sensor-side request signals and display/drop-side results of the baggage-drop sequencer.
interface baggage_drop_seq_if;
    import baggage_pkg::*;

    logic        start;
    logic        abort;
    logic [7:0]  sensor1;
    logic [7:0]  sensor2;
    logic [7:0]  sensor3;
    logic [7:0]  sensor4;
    logic [15:0] t_lim;
    logic        drop_en;

    logic        busy;
    logic        result_valid;
    logic [7:0]  height_o;
    logic [15:0] drop_time;
    logic [1:0]  verdict;
    logic        drop_activated;

    modport master (
        output start, abort, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
        input  busy, result_valid, height_o, drop_time, verdict, drop_activated
    );

    modport slave (
        input  start, abort, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
        output busy, result_valid, height_o, drop_time, verdict, drop_activated
    );

endinterface

// File: rtl/isqrt_seq.sv
// Restoring bit-serial integer square root: one root bit per clock, 12 iterations
// after the load edge, with a one-cycle done pulse on the last iteration.
module isqrt_seq
    import baggage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sqrt_clr,
    input  logic              sqrt_start,
    input  logic [RAD_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic              sqrt_done
);

    logic [RAD_W-1:0]  rad_r;
    logic [15:0]       rem_r;
    logic [ROOT_W-1:0] root_r;
    logic [3:0]        iter_r;
    logic              active_r;
    logic              done_r;

    logic [15:0]       rem_sh_s;
    logic [15:0]       trial_s;
    logic [15:0]       rem_nx_s;
    logic              bit_s;

    // One restoring step: bring down two radicand bits and try subtracting 4*root+1.
    always_comb begin
        rem_sh_s = (rem_r << 2) | {14'd0, rad_r[RAD_W-1 -: 2]};
        trial_s  = {2'b00, root_r, 2'b01};
        bit_s    = 1'b0;
        rem_nx_s = rem_sh_s;
        if (rem_sh_s >= trial_s) begin
            bit_s    = 1'b1;
            rem_nx_s = rem_sh_s - trial_s;
        end else begin
            bit_s    = 1'b0;
            rem_nx_s = rem_sh_s;
        end
    end

    // Iteration state: load on start, shift one root bit per cycle, clear on reset or abort.
    always_ff @(posedge clk) begin
        if (rst || sqrt_clr) begin
            rad_r    <= {RAD_W{1'b0}};
            rem_r    <= 16'd0;
            root_r   <= {ROOT_W{1'b0}};
            iter_r   <= 4'd0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (sqrt_start) begin
            rad_r    <= radicand;
            rem_r    <= 16'd0;
            root_r   <= {ROOT_W{1'b0}};
            iter_r   <= 4'd0;
            active_r <= 1'b1;
            done_r   <= 1'b0;
        end else if (active_r) begin
            rad_r  <= rad_r << 2;
            rem_r  <= rem_nx_s;
            root_r <= {root_r[ROOT_W-2:0], bit_s};
            iter_r <= iter_r + 4'd1;
            if (iter_r == 4'(ROOT_W - 1)) begin
                active_r <= 1'b0;
                done_r   <= 1'b1;
            end else begin
                active_r <= 1'b1;
                done_r   <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign root      = root_r;
    assign sqrt_done = done_r;

endmodule

// File: rtl/baggage_drop_seq.sv
// Multi-cycle baggage-drop controller: capture sensors, average a height, take its
// square root serially, derive the drop time and drive the actuator then cool down.
module baggage_drop_seq #(
    parameter int DROP_HOLD = 50,
    parameter int COOLDOWN  = 100,
    parameter int ROOT_W    = baggage_pkg::ROOT_W
) (
    input  logic              clk,
    input  logic              rst,
    baggage_drop_seq_if.slave bus
);
    import baggage_pkg::*;

    state_t            state_r;
    state_t            state_nx_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_nx_s;

    logic [7:0]        cap_s1_r;
    logic [7:0]        cap_s2_r;
    logic [7:0]        cap_s3_r;
    logic [7:0]        cap_s4_r;
    logic [15:0]       cap_t_lim_r;

    logic              cap_en_s;
    logic              out_en_s;
    logic              sqrt_start_s;
    logic              sqrt_clr_s;
    logic              sqrt_done_s;
    logic [ROOT_W-1:0] root_s;

    logic [9:0]        sum_s;
    logic [7:0]        height_s;
    logic [15:0]       drop_time_s;
    logic [1:0]        verdict_s;

    logic              busy_r;
    logic              result_valid_r;
    logic [7:0]        height_r;
    logic [15:0]       drop_time_r;
    logic [1:0]        verdict_r;
    logic              drop_act_r;

    // Height from the captured sensors: a zero reading drops that opposite pair.
    always_comb begin
        sum_s    = 10'd0;
        height_s = 8'd0;
        if (cap_s1_r == 8'd0 || cap_s3_r == 8'd0) begin
            sum_s    = {2'b00, cap_s2_r} + {2'b00, cap_s4_r} + 10'd1;
            height_s = 8'(sum_s >> 1);
        end else if (cap_s2_r == 8'd0 || cap_s4_r == 8'd0) begin
            sum_s    = {2'b00, cap_s1_r} + {2'b00, cap_s3_r} + 10'd1;
            height_s = 8'(sum_s >> 1);
        end else begin
            sum_s    = {2'b00, cap_s1_r} + {2'b00, cap_s2_r}
                     + {2'b00, cap_s3_r} + {2'b00, cap_s4_r} + 10'd2;
            height_s = 8'(sum_s >> 2);
        end
    end

    // Verdict from the finished root; drop_en is taken live at that moment.
    always_comb begin
        drop_time_s = root_to_drop_time(root_s);
        verdict_s   = VERDICT_NONE;
        if (!bus.drop_en) begin
            verdict_s = VERDICT_DIS;
        end else if (drop_time_s > cap_t_lim_r) begin
            verdict_s = VERDICT_SLOW;
        end else begin
            verdict_s = VERDICT_DROP;
        end
    end

    // Next-state and control strobes; abort overrides every state.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        cap_en_s     = 1'b0;
        out_en_s     = 1'b0;
        sqrt_start_s = 1'b0;
        sqrt_clr_s   = bus.abort;
        if (bus.abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        cap_en_s   = 1'b1;
                        state_nx_s = ST_CALC;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    sqrt_start_s = 1'b1;
                    state_nx_s   = ST_SQRT;
                end
                ST_SQRT: begin
                    if (sqrt_done_s) begin
                        out_en_s   = 1'b1;
                        state_nx_s = ST_CMP;
                    end else begin
                        state_nx_s = ST_SQRT;
                    end
                end
                ST_CMP: begin
                    if (verdict_r == VERDICT_DROP) begin
                        state_nx_s = ST_DROP;
                        cnt_nx_s   = 16'(DROP_HOLD - 1);
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!bus.drop_en || cnt_r == 16'd0) begin
                        state_nx_s = ST_COOL;
                        cnt_nx_s   = 16'(COOLDOWN - 1);
                    end else begin
                        cnt_nx_s   = cnt_r - 16'd1;
                    end
                end
                ST_COOL: begin
                    if (cnt_r == 16'd0) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        cnt_nx_s   = cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, capture and output registers; busy/drop follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            cap_s1_r       <= 8'd0;
            cap_s2_r       <= 8'd0;
            cap_s3_r       <= 8'd0;
            cap_s4_r       <= 8'd0;
            cap_t_lim_r    <= 16'd0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            height_r       <= 8'd0;
            drop_time_r    <= 16'd0;
            verdict_r      <= VERDICT_NONE;
            drop_act_r     <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            cnt_r          <= cnt_nx_s;
            if (cap_en_s) begin
                cap_s1_r    <= bus.sensor1;
                cap_s2_r    <= bus.sensor2;
                cap_s3_r    <= bus.sensor3;
                cap_s4_r    <= bus.sensor4;
                cap_t_lim_r <= bus.t_lim;
            end
            result_valid_r <= out_en_s;
            if (out_en_s) begin
                height_r    <= height_s;
                drop_time_r <= drop_time_s;
                verdict_r   <= verdict_s;
            end
            busy_r         <= (state_nx_s != ST_IDLE);
            drop_act_r     <= (state_nx_s == ST_DROP);
        end
    end

    isqrt_seq u_isqrt (
        .clk        (clk),
        .rst        (rst),
        .sqrt_clr   (sqrt_clr_s),
        .sqrt_start (sqrt_start_s),
        .radicand   ({height_s, 16'h0000}),
        .root       (root_s),
        .sqrt_done  (sqrt_done_s)
    );

    assign bus.busy           = busy_r;
    assign bus.result_valid   = result_valid_r;
    assign bus.height_o       = height_r;
    assign bus.drop_time      = drop_time_r;
    assign bus.verdict        = verdict_r;
    assign bus.drop_activated = drop_act_r;

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Scoreboard bench for baggage_drop_seq: the driver pushes expected results from a
// reference model, a negedge monitor pops and compares every result_valid pulse.
module tb_baggage_drop_seq;

    localparam int DH = 50;
    localparam int CD = 100;

    typedef struct {
        int     h;
        int     dt;
        int     v;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    exp_t   sb_q[$];
    exp_t   cur;
    exp_t   mon_e;
    int     last_h = 0;
    int     last_v = 0;

    baggage_drop_seq_if bus();

    baggage_drop_seq #(.DROP_HOLD(DH), .COOLDOWN(CD), .ROOT_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int model_height(input int a, input int b, input int c, input int d);
        if (a == 0 || c == 0) return (b + d + 1) / 2;
        else if (b == 0 || d == 0) return (a + c + 1) / 2;
        else return (a + b + c + d + 2) / 4;
    endfunction

    function automatic int model_root(input int h);
        longint rad;
        longint r;
        rad = longint'(h) * 65536;
        r = longint'($sqrt(real'(rad)));
        while (r * r > rad) r--;
        while ((r + 1) * (r + 1) <= rad) r++;
        return int'(r);
    endfunction

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.result_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("height_o", bus.height_o, mon_e.h);
                check("drop_time", bus.drop_time, mon_e.dt);
                check("verdict", bus.verdict, mon_e.v);
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input int a, input int b, input int c, input int d,
                         input int tl, input bit den);
        exp_t e;
        bus.sensor1 = 8'(a);
        bus.sensor2 = 8'(b);
        bus.sensor3 = 8'(c);
        bus.sensor4 = 8'(d);
        bus.t_lim   = 16'(tl);
        bus.drop_en = den;
        bus.start   = 1'b1;
        e.h   = model_height(a, b, c, d);
        e.dt  = model_root(e.h) / 2;
        e.v   = !den ? 3 : ((e.dt > (tl & 32'hFFFF)) ? 2 : 1);
        e.cyc = cyc + 15;
        sb_q.push_back(e);
        cur = e;
    endtask

    task automatic run_txn(input int a, input int b, input int c, input int d, input int tl,
                           input bit den, input int fall_at, input bit cool_start,
                           input bit rst_drop);
        int g;
        int cnt;
        g = 0;
        while (bus.busy && g < 400) begin @(negedge clk); g++; end
        if (bus.busy) check("idle_wait_timeout", 1, 0);
        issue(a, b, c, d, tl, den);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.sensor1 = 8'($urandom);
        bus.sensor2 = 8'($urandom);
        bus.sensor3 = 8'($urandom);
        bus.sensor4 = 8'($urandom);
        bus.t_lim   = 16'($urandom);
        g = 0;
        while (!bus.result_valid && g < 30) begin @(negedge clk); g++; end
        if (!bus.result_valid) begin
            check("result_valid_timeout", 0, 1);
            sb_q.delete();
            return;
        end
        last_h = cur.h;
        last_v = cur.v;
        if (cur.v != 1) begin
            @(negedge clk);
            check("busy_after_no_drop", bus.busy, 0);
            check("drop_never_rises", bus.drop_activated, 0);
        end else begin
            cnt = 0;
            @(negedge clk);
            while (bus.drop_activated && cnt < 200) begin
                cnt++;
                if (rst_drop && cnt == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rst_clears_outputs",
                          {bus.busy, bus.result_valid, bus.height_o, bus.drop_time,
                           bus.verdict, bus.drop_activated}, 0);
                    last_h = 0;
                    last_v = 0;
                    return;
                end
                if (cnt == fall_at) bus.drop_en = 1'b0;
                @(negedge clk);
            end
            check("drop_hold_len", cnt, (fall_at > 0) ? fall_at : DH);
            cnt = 0;
            while (bus.busy && cnt < 300) begin
                cnt++;
                bus.start = (cool_start && cnt == 5);
                @(negedge clk);
            end
            bus.start = 1'b0;
            check("cooldown_len", cnt, CD);
            bus.drop_en = 1'b1;
        end
    endtask

    initial begin
        int a, b, c, d, h, dt, tl;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.sensor1 = 8'd0; bus.sensor2 = 8'd0; bus.sensor3 = 8'd0; bus.sensor4 = 8'd0;
        bus.t_lim = 16'd0; bus.drop_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs_zero",
              {bus.busy, bus.result_valid, bus.height_o, bus.drop_time,
               bus.verdict, bus.drop_activated}, 0);

        // Nominal drop, with a start pulse during cooldown that must be ignored.
        run_txn(100, 100, 100, 100, 16'h0600, 1'b1, 0, 1'b1, 1'b0);
        // Faulty sensor1, drop_time equal to the limit passes.
        run_txn(0, 60, 90, 65, 16'h03F7, 1'b1, 0, 1'b0, 1'b0);
        // Same sensors, limit one LSB lower: too slow.
        run_txn(0, 60, 90, 65, 16'h03F6, 1'b1, 0, 1'b0, 1'b0);
        // Drop disabled.
        run_txn(100, 100, 100, 100, 16'h0600, 1'b0, 0, 1'b0, 1'b0);
        // drop_en falls on cycle 10 of DROP.
        run_txn(120, 110, 130, 100, 16'hFFFF, 1'b1, 10, 1'b0, 1'b0);

        // Abort at E7 during SQRT, then a start one cycle later.
        issue(200, 200, 200, 200, 16'h0800, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        void'(sb_q.pop_back());
        check("abort_busy_low", bus.busy, 0);
        check("abort_drop_low", bus.drop_activated, 0);
        check("abort_keeps_height", bus.height_o, last_h);
        check("abort_keeps_verdict", bus.verdict, last_v);
        run_txn(10, 0, 30, 40, 16'h0200, 1'b1, 0, 1'b0, 1'b0);

        // start and abort together in IDLE: abort wins, nothing captured.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy_low", bus.busy, 0);
        repeat (20) @(negedge clk);
        check("start_abort_no_result_pending", sb_q.size(), 0);

        // Randomized transactions against the model.
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
            b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
            c = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
            h  = model_height(a, b, c, d);
            dt = model_root(h) / 2;
            if ($urandom_range(0, 1) == 1)
                tl = (dt + int'($urandom_range(0, 2)) - 1) & 32'hFFFF;
            else
                tl = int'($urandom_range(0, 65535));
            run_txn(a, b, c, d, tl, ($urandom_range(0, 4) != 0), 0, 1'b0, 1'b0);
        end

        // Reset in the middle of DROP.
        run_txn(100, 100, 100, 100, 16'h0600, 1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("post_rst_busy_low", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
